pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid.sv | 127 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline register with a skid slot: in_ready depends only on registered state,
// so upstream never sees a combinational path from out_ready.
module pipe_stage_skid #(
  parameter int DATA_W              = 32,
  parameter int NLANES              = 2,
  parameter int RD_W                = 5,
  parameter int CTRL_W              = 4,
  parameter int ZERO_CTRL_ON_BUBBLE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NLANES*DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]          in_rd,
  input  logic [CTRL_W-1:0]        in_ctrl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NLANES*DATA_W-1:0] out_data,
  output logic [RD_W-1:0]          out_rd,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [1:0]               occupancy
);

  localparam int DW      = NLANES * DATA_W;
  localparam int ENTRY_W = DW + RD_W + CTRL_W;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // The source holds its entry stable until it is taken; ready never depends on valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ENTRY_W-1:0]   r_main;
  logic [ENTRY_W-1:0]   r_skid;
  logic [ENTRY_W-1:0]   w_in_entry;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_load_main_in;
  logic                 w_load_main_skid;
  logic                 w_load_skid;

  assign w_in_entry = {in_data, in_rd, in_ctrl};
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) w_state_nxt = ST_ONE;
        ST_ONE: begin
          if (w_in_fire && !w_out_fire)      w_state_nxt = ST_TWO;
          else if (!w_in_fire && w_out_fire) w_state_nxt = ST_EMPTY;
        end
        ST_TWO:   if (w_out_fire) w_state_nxt = ST_ONE;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (r_state)
      ST_ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      ST_TWO: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: ;
    endcase
  end

  // Flush suppresses every load; the head keeps its last contents as a visible bubble.
  assign w_load_main_in   = !flush && w_in_fire &&
                            ((r_state == ST_EMPTY) || ((r_state == ST_ONE) && w_out_fire));
  assign w_load_skid      = !flush && w_in_fire && (r_state == ST_ONE) && !w_out_fire;
  assign w_load_main_skid = !flush && (r_state == ST_TWO) && w_out_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= w_in_entry;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_entry;
      end
    end
  end

  assign out_data = r_main[ENTRY_W-1 -: DW];
  assign out_rd   = r_main[CTRL_W +: RD_W];

  always_comb begin
    out_ctrl = r_main[CTRL_W-1:0];
    if ((ZERO_CTRL_ON_BUBBLE != 0) && !out_valid) begin
      out_ctrl = '0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed handshake/flush/reset cases on the default configuration,
// plus a long random ready/valid stream on a 3-lane, 16-bit configuration.
module tb_pipe_stage_skid;

  localparam int A_DW = 64;
  localparam int A_EW = A_DW + 5 + 4;
  localparam int B_DW = 48;
  localparam int B_EW = B_DW + 5 + 4;
  localparam int N_RAND = 1000;

  logic clk;
  logic reset;

  logic            a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [A_DW-1:0] a_in_data, a_out_data;
  logic [4:0]      a_in_rd, a_out_rd;
  logic [3:0]      a_in_ctrl, a_out_ctrl;
  logic [1:0]      a_occ;

  logic            b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [B_DW-1:0] b_in_data, b_out_data;
  logic [4:0]      b_in_rd, b_out_rd;
  logic [3:0]      b_in_ctrl, b_out_ctrl;
  logic [1:0]      b_occ;

  logic [A_EW-1:0] exp_q_a[$];
  logic [B_EW-1:0] exp_q_b[$];

  int checks = 0;
  int errors = 0;
  int b_rcv  = 0;

  pipe_stage_skid u_dut_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_rd(a_in_rd), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_rd(a_out_rd), .out_ctrl(a_out_ctrl),
    .occupancy(a_occ)
  );

  pipe_stage_skid #(.DATA_W(16), .NLANES(3)) u_dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_rd(b_in_rd), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_rd(b_out_rd), .out_ctrl(b_out_ctrl),
    .occupancy(b_occ)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [A_DW-1:0] d, input logic [4:0] rd, input logic [3:0] ctrl);
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_rd    = rd;
    a_in_ctrl  = ctrl;
  endtask

  // Scoreboard A: deliveries pop first, then flush drops held entries or an accepted input is queued.
  always @(negedge clk) begin
    if (reset) begin
      exp_q_a.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (exp_q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_out actual %0h required none", {a_out_data, a_out_rd, a_out_ctrl});
        end else begin
          check("a_out_entry", 128'({a_out_data, a_out_rd, a_out_ctrl}), 128'(exp_q_a.pop_front()));
        end
      end
      if (a_flush) exp_q_a.delete();
      else if (a_in_valid && a_in_ready) exp_q_a.push_back({a_in_data, a_in_rd, a_in_ctrl});
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      exp_q_b.delete();
    end else begin
      if (b_out_valid && b_out_ready) begin
        b_rcv++;
        if (exp_q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_out actual %0h required none", {b_out_data, b_out_rd, b_out_ctrl});
        end else begin
          check("b_out_entry", 128'({b_out_data, b_out_rd, b_out_ctrl}), 128'(exp_q_b.pop_front()));
        end
      end
      if (b_flush) exp_q_b.delete();
      else if (b_in_valid && b_in_ready) exp_q_b.push_back({b_in_data, b_in_rd, b_in_ctrl});
    end
  end

  initial begin
    int sent;
    int cyc;
    logic acc;
    reset = 1'b1;
    a_flush = 0; a_in_valid = 0; a_in_data = '0; a_in_rd = '0; a_in_ctrl = '0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_data = '0; b_in_rd = '0; b_in_ctrl = '0; b_out_ready = 0;
    repeat (2) step();
    check("rst_out_valid", 128'(a_out_valid), 128'(0));
    check("rst_in_ready", 128'(a_in_ready), 128'(1));
    check("rst_occ", 128'(a_occ), 128'(0));
    check("rst_out_data", 128'(a_out_data), 128'(0));
    check("rst_out_rd", 128'(a_out_rd), 128'(0));
    check("rst_out_ctrl", 128'(a_out_ctrl), 128'(0));
    reset = 1'b0;
    step();

    // Pass-through
    a_out_ready = 1'b1;
    drive_a({32'h5, 32'h1234}, 5'd7, 4'b0001);
    step();
    a_in_valid = 1'b0;
    check("pt_out_valid", 128'(a_out_valid), 128'(1));
    check("pt_out_data", 128'(a_out_data), 128'(64'h0000_0005_0000_1234));
    check("pt_out_rd", 128'(a_out_rd), 128'(7));
    check("pt_out_ctrl", 128'(a_out_ctrl), 128'(1));
    check("pt_occ", 128'(a_occ), 128'(1));
    step();
    check("pt_drain_occ", 128'(a_occ), 128'(0));
    check("pt_drain_ctrl", 128'(a_out_ctrl), 128'(0));

    // Backpressure: A and B held, C waits upstream
    a_out_ready = 1'b0;
    drive_a(64'hA, 5'd1, 4'b0001);
    step();
    check("bp_occ1", 128'(a_occ), 128'(1));
    check("bp_ready1", 128'(a_in_ready), 128'(1));
    drive_a(64'hB, 5'd2, 4'b0011);
    step();
    check("bp_occ2", 128'(a_occ), 128'(2));
    check("bp_ready2", 128'(a_in_ready), 128'(0));
    drive_a(64'hC, 5'd3, 4'b0101);
    step();
    check("bp_occ_hold", 128'(a_occ), 128'(2));
    check("bp_head_stable", 128'(a_out_data), 128'(64'hA));
    a_out_ready = 1'b1;
    step();
    check("bp_head_b", 128'(a_out_data), 128'(64'hB));
    check("bp_occ_b", 128'(a_occ), 128'(1));
    step();
    a_in_valid = 1'b0;
    check("bp_head_c", 128'(a_out_data), 128'(64'hC));
    check("bp_head_c_rd", 128'(a_out_rd), 128'(3));
    step();
    check("bp_empty", 128'(a_occ), 128'(0));

    // Flush while full with a simultaneous input
    a_out_ready = 1'b0;
    drive_a(64'hE, 5'd4, 4'b0001);
    step();
    drive_a(64'hF, 5'd5, 4'b0001);
    step();
    check("fl_occ_full", 128'(a_occ), 128'(2));
    a_flush = 1'b1;
    drive_a(64'h6, 5'd6, 4'b0001);
    step();
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    check("fl_occ", 128'(a_occ), 128'(0));
    check("fl_out_valid", 128'(a_out_valid), 128'(0));
    check("fl_out_ctrl", 128'(a_out_ctrl), 128'(0));
    check("fl_in_ready", 128'(a_in_ready), 128'(1));
    a_out_ready = 1'b1;
    step();
    check("fl_no_deliver", 128'(a_out_valid), 128'(0));

    // Bubble control keeps rd/data, zeroes ctrl
    drive_a(64'hBEEF, 5'd9, 4'b1111);
    step();
    a_in_valid = 1'b0;
    check("bub_ctrl_live", 128'(a_out_ctrl), 128'(4'b1111));
    step();
    check("bub_valid", 128'(a_out_valid), 128'(0));
    check("bub_ctrl", 128'(a_out_ctrl), 128'(0));
    check("bub_rd_hold", 128'(a_out_rd), 128'(9));
    check("bub_data_hold", 128'(a_out_data), 128'(64'hBEEF));

    // Asynchronous reset between edges while full
    a_out_ready = 1'b0;
    drive_a(64'h11, 5'd11, 4'b0001);
    step();
    drive_a(64'h12, 5'd12, 4'b0001);
    step();
    a_in_valid = 1'b0;
    check("ar_occ_full", 128'(a_occ), 128'(2));
    #2 reset = 1'b1;
    #1;
    check("ar_out_valid", 128'(a_out_valid), 128'(0));
    check("ar_in_ready", 128'(a_in_ready), 128'(1));
    check("ar_occ", 128'(a_occ), 128'(0));
    check("ar_out_data", 128'(a_out_data), 128'(0));
    @(negedge clk);
    #1 reset = 1'b0;
    step();
    a_out_ready = 1'b1;
    drive_a(64'hD, 5'd13, 4'b0010);
    step();
    a_in_valid = 1'b0;
    check("ar_d_valid", 128'(a_out_valid), 128'(1));
    check("ar_d_data", 128'(a_out_data), 128'(64'hD));
    check("ar_d_occ", 128'(a_occ), 128'(1));
    repeat (2) step();

    // Random ready/valid stream on the 3-lane instance
    sent = 0;
    cyc  = 0;
    while (sent < N_RAND && cyc < 20000) begin
      b_in_data   = {16'(sent), 16'(sent ^ 16'h5a5a), 16'(sent * 7)};
      b_in_rd     = 5'(sent);
      b_in_ctrl   = 4'(sent);
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = b_in_valid && b_in_ready;
      step();
      if (acc) sent++;
      cyc++;
    end
    check("rand_sent", 128'(sent), 128'(N_RAND));
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    repeat (5) step();
    check("rand_received", 128'(b_rcv), 128'(N_RAND));
    check("rand_q_empty", 128'(exp_q_b.size()), 128'(0));
    check("dir_q_empty", 128'(exp_q_a.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
